// File: rtl/wt_ptr_flag_gen.sv
`default_nettype none
// ============================================================================
// Module   : wt_ptr_flag_gen
// Purpose  : Write-domain pointer and status-flag generator for the async
//            FIFO. Owns the binary/Gray write pointer, synchronises the
//            read-side Gray pointer, and registers full / almost_full /
//            push_on_full_error for the write-side control path.
// Revision : 1.0 - initial release
// ============================================================================
module wt_ptr_flag_gen #(
    parameter int ADDR_W         = 4,
    parameter int ALMOST_FULL_TH = 2
) (
    input  logic              wt_clk,
    input  logic              rst_in_wt,
    input  logic              wt_en,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic              mem_wt_en,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W:0]   wt_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic              push_on_full_error
);

    localparam int                   c_PTR_W = ADDR_W + 1;
    localparam logic [c_PTR_W-1:0]   c_DEPTH = c_PTR_W'(1 << ADDR_W);
    localparam logic [c_PTR_W-1:0]   c_AF_TH = c_PTR_W'(ALMOST_FULL_TH);

    // Registered state
    logic [c_PTR_W-1:0] wbin_q;
    logic [c_PTR_W-1:0] wgray_q;
    logic [c_PTR_W-1:0] rs1_q;
    logic [c_PTR_W-1:0] rs2_q;
    logic               full_q;
    logic               afull_q;
    logic               err_q;

    // Next-state and helper values
    logic               push;
    logic [c_PTR_W-1:0] wbin_d;
    logic [c_PTR_W-1:0] wgray_d;
    logic [c_PTR_W-1:0] rbin_s;
    logic [c_PTR_W-1:0] full_ref;
    logic [c_PTR_W-1:0] occ_d;
    logic [c_PTR_W-1:0] free_d;
    logic               full_d;
    logic               afull_d;
    logic               err_d;

    // Next pointer and flags, all derived from the post-push pointer so the
    // flags describe the FIFO as it will be after this edge.
    always_comb begin
        push    = wt_en & ~full_q;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, push};
        wgray_d = wbin_d ^ (wbin_d >> 1);

        // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
        rbin_s = '0;
        for (int i = 0; i < c_PTR_W; i++) begin
            rbin_s[i] = ^(rs2_q >> i);
        end

        // Full when the write pointer is exactly one lap ahead of the read pointer
        full_ref = {~rs2_q[ADDR_W:ADDR_W-1], rs2_q[ADDR_W-2:0]};
        full_d   = (wgray_d == full_ref);

        // Occupancy uses the stale synchronised read pointer, so it can only
        // over-estimate and the flags err on the safe side.
        occ_d   = wbin_d - rbin_s;
        free_d  = c_DEPTH - occ_d;
        afull_d = (free_d <= c_AF_TH);

        err_d = wt_en & full_q;
    end

    // Two-flop synchroniser for the read-domain Gray pointer
    always_ff @(posedge wt_clk) begin
        if (rst_in_wt) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            rs1_q <= rd_ptr_gray;
            rs2_q <= rs1_q;
        end
    end

    // Write pointer and status flag registers
    always_ff @(posedge wt_clk) begin
        if (rst_in_wt) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            err_q   <= err_d;
        end
    end

    // The memory strobe is also gated by reset: a push request in a reset
    // cycle must not corrupt the memory while the pointer is being cleared.
    assign mem_wt_en          = wt_en & ~full_q & ~rst_in_wt;
    assign wt_addr            = wbin_q[ADDR_W-1:0];
    assign wt_ptr_gray        = wgray_q;
    assign full               = full_q;
    assign almost_full        = afull_q;
    assign push_on_full_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wt_ptr_flag_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_ptr_flag_gen
// Purpose  : Self-checking bench for wt_ptr_flag_gen. A count-based FIFO
//            model (write count, read count, delayed read view) predicts
//            every output; directed scenarios plus a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_ptr_flag_gen;

    localparam int ADDR_W = 4;
    localparam int TH     = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              wt_clk;
    logic              rst_in_wt;
    logic              wt_en;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic              mem_wt_en;
    logic [ADDR_W-1:0] wt_addr;
    logic [ADDR_W:0]   wt_ptr_gray;
    logic              full;
    logic              almost_full;
    logic              push_on_full_error;

    wt_ptr_flag_gen #(
        .ADDR_W        (ADDR_W),
        .ALMOST_FULL_TH(TH)
    ) dut (
        .wt_clk            (wt_clk),
        .rst_in_wt         (rst_in_wt),
        .wt_en             (wt_en),
        .rd_ptr_gray       (rd_ptr_gray),
        .mem_wt_en         (mem_wt_en),
        .wt_addr           (wt_addr),
        .wt_ptr_gray       (wt_ptr_gray),
        .full              (full),
        .almost_full       (almost_full),
        .push_on_full_error(push_on_full_error)
    );

    initial wt_clk = 1'b0;
    always #5 wt_clk = ~wt_clk;

    // Reference model: total pushes accepted, total pops by the read side,
    // and the read count as the write domain sees it two edges late.
    int checks   = 0;
    int failures = 0;
    int wcnt     = 0;
    int rcnt     = 0;
    int rq[$];
    bit full_m, af_m, err_m;
    int pulses;
    logic [ADDR_W:0] prev_gray;

    function automatic logic [ADDR_W:0] gray(input int v);
        logic [ADDR_W:0] b;
        b = ADDR_W'(0) + (v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One write-clock cycle: drive inputs, check the strobe, clock, update
    // the model, check the registered outputs.
    task automatic step(input bit en, input bit rst);
        int seen;
        int occ;
        wt_en       = en;
        rst_in_wt   = rst;
        rd_ptr_gray = gray(rcnt);
        #1;
        chk("mem_wt_en", 32'(mem_wt_en), 32'(en & !full_m & !rst));
        if (mem_wt_en === 1'b1)
            chk("no_write_while_full", 32'((wcnt - rcnt) < DEPTH), 32'd1);
        @(posedge wt_clk);
        #1;
        if (rst) begin
            wcnt   = 0;
            full_m = 0;
            af_m   = 0;
            err_m  = 0;
            rq     = {0, 0};
        end else begin
            err_m = en & full_m;
            if (en && !full_m) wcnt++;
            seen = rq.pop_front();
            rq.push_back(rcnt);
            occ    = wcnt - seen;
            full_m = (occ == DEPTH);
            af_m   = ((DEPTH - occ) <= TH);
        end
        chk("wt_addr", 32'(wt_addr), 32'(wcnt % DEPTH));
        chk("wt_ptr_gray", 32'(wt_ptr_gray), 32'(gray(wcnt)));
        chk("full", 32'(full), 32'(full_m));
        chk("almost_full", 32'(almost_full), 32'(af_m));
        chk("push_on_full_error", 32'(push_on_full_error), 32'(err_m));
        if ((wcnt - rcnt) >= DEPTH - TH)
            chk("af_at_threshold", 32'(almost_full), 32'd1);
    endtask

    initial begin
        wt_en       = 1'b0;
        rst_in_wt   = 1'b1;
        rd_ptr_gray = '0;
        rq          = {0, 0};

        // T1: reset with push requested
        rcnt = 0;
        step(1, 1);
        step(1, 1);
        chk("t1_all_zero", 32'({wt_addr, wt_ptr_gray, full, almost_full, push_on_full_error}), 32'd0);

        // T2: fill from empty with wt_en held for 18 cycles
        pulses = 0;
        for (int i = 1; i <= 18; i++) begin
            if (i <= 16) pulses++;
            step(1, 0);
            chk("t2_almost_full", 32'(almost_full), 32'(i >= 14));
            chk("t2_full", 32'(full), 32'(i >= 16));
            chk("t2_error", 32'(push_on_full_error), 32'(i >= 17));
        end
        chk("t2_addr_wrapped", 32'(wt_addr), 32'd0);

        // T3: one pop releases full exactly three edges later
        rcnt = 1;
        step(0, 0);
        chk("t3_full_edge1", 32'(full), 32'd1);
        step(0, 0);
        chk("t3_full_edge2", 32'(full), 32'd1);
        step(0, 0);
        chk("t3_full_edge3", 32'(full), 32'd0);
        chk("t3_almost_full", 32'(almost_full), 32'd1);
        step(1, 0);
        chk("t3_refilled", 32'(full), 32'd1);

        // T4: 40 pushes at steady occupancy 4, through the pointer wrap
        rcnt = 0;
        step(0, 1);
        for (int i = 0; i < 40; i++) begin
            if (wcnt - rcnt >= 4) rcnt++;
            prev_gray = wt_ptr_gray;
            step(1, 0);
            chk("t4_gray_1bit", 32'($countones(prev_gray ^ wt_ptr_gray)), 32'd1);
            chk("t4_never_full", 32'(full), 32'd0);
        end

        // T5: reset at occupancy 10, read side reset alongside
        rcnt = 0;
        step(0, 1);
        for (int i = 0; i < 10; i++) step(1, 0);
        chk("t5_occ10_addr", 32'(wt_addr), 32'd10);
        rcnt = 0;
        step(1, 1);
        chk("t5_addr_zero", 32'(wt_addr), 32'd0);
        chk("t5_flags_zero", 32'({full, almost_full, push_on_full_error}), 32'd0);
        step(1, 0);
        chk("t5_first_push", 32'(wt_addr), 32'd1);

        // T6: random pushes and pops against the model
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 2) == 0 && rcnt < wcnt) rcnt++;
            step(($urandom % 4) != 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
